// File: rtl/mem_access_unit.sv
// Load/store initiator for the 32-bit byte-banked data memory: turns byte/halfword/word
// CPU requests into aligned word accesses, doing read-modify-write for sub-word stores.
module mem_access_unit #(
   parameter int READ_LAT = 1,
   parameter int ADDR_W   = 32
) (
   input  logic              Clk,
   input  logic              Reset_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic              resp_err,
   output logic [ADDR_W-1:0] mem_raddress,
   output logic [ADDR_W-1:0] mem_waddress,
   output logic [31:0]       mem_datain,
   input  logic [31:0]       mem_dataout,
   output logic              mem_wr
);

   typedef enum logic [2:0] {IDLE, RD_WAIT, MERGE, WRITE, DONE} stateT;

   stateT             stateReg, stateNext;
   logic [ADDR_W-1:0] addrReg;
   logic [1:0]        sizeReg;
   logic              writeReg;
   logic              unsignedReg;
   logic              errReg;
   logic [15:0]       wdataReg;
   logic [2:0]        cntReg;
   logic [31:0]       datainReg;
   logic [31:0]       rdataReg;

   logic              misalign;
   logic              wordStore;
   logic [15:0]       laneHalf;
   logic [7:0]        laneByte;
   logic [31:0]       loadExt;
   logic [31:0]       merged;

   assign misalign  = (req_size == 2'b11)
                    | ((req_size == 2'b01) & req_addr[0])
                    | ((req_size == 2'b10) & (req_addr[1:0] != 2'b00));
   assign wordStore = req_write & (req_size == 2'b10);

   assign laneHalf = addrReg[1] ? mem_dataout[31:16] : mem_dataout[15:0];
   assign laneByte = addrReg[0] ? laneHalf[15:8] : laneHalf[7:0];

   always_comb begin
      loadExt = mem_dataout;
      case (sizeReg)
         2'b00:   loadExt = unsignedReg ? {24'h0, laneByte} : {{24{laneByte[7]}}, laneByte};
         2'b01:   loadExt = unsignedReg ? {16'h0, laneHalf} : {{16{laneHalf[15]}}, laneHalf};
         default: loadExt = mem_dataout;
      endcase
   end

   // Store lanes come from the low store-data bytes; everything else keeps the read word.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : genLane
         localparam logic [1:0] LANE = 2'(gi);
         logic       hit;
         logic [7:0] src;
         assign hit = (sizeReg == 2'b00) ? (addrReg[1:0] == LANE) : (addrReg[1] == LANE[1]);
         assign src = ((sizeReg == 2'b01) && LANE[0]) ? wdataReg[15:8] : wdataReg[7:0];
         assign merged[8*gi +: 8] = hit ? src : mem_dataout[8*gi +: 8];
      end
   endgenerate

   // Sub-word stores leave RD_WAIT one cycle early: MERGE itself is the cycle the read
   // word is valid on mem_dataout, so it is merged straight from the bus.
   always_comb begin
      stateNext = stateReg;
      case (stateReg)
         IDLE: begin
            if (req_valid) begin
               if (misalign)       stateNext = DONE;
               else if (wordStore) stateNext = WRITE;
               else                stateNext = RD_WAIT;
            end
         end
         RD_WAIT: begin
            if (writeReg && cntReg == 3'd1)       stateNext = MERGE;
            else if (!writeReg && cntReg == 3'd0) stateNext = DONE;
         end
         MERGE:   stateNext = WRITE;
         WRITE:   stateNext = DONE;
         DONE:    stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         stateReg    <= IDLE;
         addrReg     <= '0;
         sizeReg     <= 2'b00;
         writeReg    <= 1'b0;
         unsignedReg <= 1'b0;
         errReg      <= 1'b0;
         wdataReg    <= 16'h0;
         cntReg      <= 3'd0;
         datainReg   <= 32'h0;
         rdataReg    <= 32'h0;
      end else begin
         stateReg <= stateNext;
         case (stateReg)
            IDLE: begin
               if (req_valid) begin
                  addrReg     <= req_addr;
                  sizeReg     <= req_size;
                  writeReg    <= req_write;
                  unsignedReg <= req_unsigned;
                  errReg      <= misalign;
                  wdataReg    <= req_wdata[15:0];
                  cntReg      <= 3'(READ_LAT);
                  rdataReg    <= 32'h0;
                  if (wordStore && !misalign)
                     datainReg <= req_wdata;
               end
            end
            RD_WAIT: begin
               cntReg <= cntReg - 3'd1;
               if (!writeReg && cntReg == 3'd0)
                  rdataReg <= loadExt;
            end
            MERGE:   datainReg <= merged;
            default: ;
         endcase
      end
   end

   assign req_ready    = (stateReg == IDLE);
   assign resp_valid   = (stateReg == DONE);
   assign resp_err     = (stateReg == DONE) & errReg;
   assign resp_rdata   = rdataReg;
   assign mem_raddress = {addrReg[ADDR_W-1:2], 2'b00};
   assign mem_waddress = {addrReg[ADDR_W-1:2], 2'b00};
   assign mem_datain   = datainReg;
   assign mem_wr       = (stateReg == WRITE);

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench: one unit with READ_LAT=1 and one with READ_LAT=3, each on a
// behavioural memory with a READ_LAT-deep registered read path.
module tb_mem_access_unit;

   logic Clk = 1'b0;
   always #5 Clk = ~Clk;
   logic Reset_n;

   logic        rv1, rdy1, rw1, ru1, vld1, err1, wr1;
   logic [1:0]  rs1;
   logic [31:0] ra1, rwd1, rdata1, raddr1, waddr1, din1, dout1;
   logic        rv3, rdy3, rw3, ru3, vld3, err3, wr3;
   logic [1:0]  rs3;
   logic [31:0] ra3, rwd3, rdata3, raddr3, waddr3, din3, dout3;

   mem_access_unit #(.READ_LAT(1), .ADDR_W(32)) dut (
      .Clk(Clk), .Reset_n(Reset_n),
      .req_valid(rv1), .req_ready(rdy1), .req_write(rw1), .req_size(rs1),
      .req_unsigned(ru1), .req_addr(ra1), .req_wdata(rwd1),
      .resp_valid(vld1), .resp_rdata(rdata1), .resp_err(err1),
      .mem_raddress(raddr1), .mem_waddress(waddr1), .mem_datain(din1),
      .mem_dataout(dout1), .mem_wr(wr1));

   mem_access_unit #(.READ_LAT(3), .ADDR_W(32)) dut3 (
      .Clk(Clk), .Reset_n(Reset_n),
      .req_valid(rv3), .req_ready(rdy3), .req_write(rw3), .req_size(rs3),
      .req_unsigned(ru3), .req_addr(ra3), .req_wdata(rwd3),
      .resp_valid(vld3), .resp_rdata(rdata3), .resp_err(err3),
      .mem_raddress(raddr3), .mem_waddress(waddr3), .mem_datain(din3),
      .mem_dataout(dout3), .mem_wr(wr3));

   // Memory models and event monitors
   logic [31:0] mem1 [0:63];
   logic [31:0] mem3 [0:63];
   logic [31:0] pipe1;
   logic [31:0] pipe3 [0:2];
   int          wrCnt1 = 0, vldCnt1 = 0, accCnt3 = 0;
   logic [31:0] lastWa1 = 32'h0, lastDin1 = 32'h0;

   always @(posedge Clk) begin
      if (wr1) begin
         mem1[waddr1[7:2]] <= din1;
         wrCnt1   <= wrCnt1 + 1;
         lastWa1  <= waddr1;
         lastDin1 <= din1;
      end
      if (vld1) vldCnt1 <= vldCnt1 + 1;
      pipe1 <= mem1[raddr1[7:2]];
   end
   assign dout1 = pipe1;

   always @(posedge Clk) begin
      if (wr3) mem3[waddr3[7:2]] <= din3;
      if (rv3 && rdy3) accCnt3 <= accCnt3 + 1;
      pipe3[0] <= mem3[raddr3[7:2]];
      pipe3[1] <= pipe3[0];
      pipe3[2] <= pipe3[1];
   end
   assign dout3 = pipe3[2];

   int          checks = 0;
   int          failures = 0;
   int          lat1;
   logic [31:0] rd1;
   logic        er1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Called at #1 after an edge with unit 1 idle; returns one cycle after DONE.
   task automatic issue1(input logic w, input logic [1:0] s, input logic u,
                         input logic [31:0] a, input logic [31:0] d);
      rw1 = w; rs1 = s; ru1 = u; ra1 = a; rwd1 = d; rv1 = 1'b1;
      @(posedge Clk); #1;
      rv1 = 1'b0;
      lat1 = 1;
      while (!vld1 && lat1 < 20) begin
         @(posedge Clk); #1;
         lat1++;
      end
      rd1 = rdata1;
      er1 = err1;
      $display("txn u1 write=%0d size=%0d uns=%0d addr=%h wdata=%h lat=%0d rdata=%h err=%0d",
               w, s, u, a, d, lat1, rd1, er1);
      @(posedge Clk); #1;
   endtask

   task automatic txn1(input string tag, input logic w, input logic [1:0] s, input logic u,
                       input logic [31:0] a, input logic [31:0] d,
                       input int expLat, input logic [31:0] expRd, input logic expErr);
      issue1(w, s, u, a, d);
      chk({tag, "_lat"}, lat1, expLat);
      chk({tag, "_rdata"}, rd1, expRd);
      chk({tag, "_err"}, er1, expErr);
   endtask

   // Queued requests for the READ_LAT=3 handshake run
   logic        qW   [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
   logic [1:0]  qS   [4] = '{2'b10, 2'b10, 2'b00, 2'b01};
   logic        qU   [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
   logic [31:0] qA   [4] = '{32'h40, 32'h40, 32'h41, 32'h40};
   logic [31:0] qD   [4] = '{32'hCAFEF00D, 32'h0, 32'h77, 32'h0};
   int          qLat [4] = '{2, 5, 6, 5};
   logic [31:0] qRd  [4] = '{32'h0, 32'hCAFEF00D, 32'h0, 32'h0000770D};

   initial begin
      int          wc, vc, waitC, lat;
      logic        acc, busyBad;
      logic [31:0] old;

      Reset_n = 1'b0;
      rv1 = 0; rw1 = 0; rs1 = 0; ru1 = 0; ra1 = 0; rwd1 = 0;
      rv3 = 0; rw3 = 0; rs3 = 0; ru3 = 0; ra3 = 0; rwd3 = 0;
      repeat (2) @(posedge Clk);
      #1;
      chk("rst_ready", rdy1, 1'b1);
      chk("rst_valid", vld1, 1'b0);
      chk("rst_rdata", rdata1, 32'h0);
      chk("rst_err", err1, 1'b0);
      chk("rst_wr", wr1, 1'b0);
      chk("rst_datain", din1, 32'h0);
      chk("rst_raddr", raddr1, 32'h0);
      chk("rst_waddr", waddr1, 32'h0);
      chk("rst_ready3", rdy3, 1'b1);
      Reset_n = 1'b1;
      @(posedge Clk); #1;

      // Word store then word load
      wc = wrCnt1;
      txn1("wst", 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 2, 32'h0, 0);
      chk("wst_wrcnt", wrCnt1 - wc, 1);
      chk("wst_waddr", lastWa1, 32'h10);
      chk("wst_datain", lastDin1, 32'hDEADBEEF);
      txn1("wld", 0, 2'b10, 0, 32'h10, 32'h0, 3, 32'hDEADBEEF, 0);

      // Sub-word read-modify-write stores
      txn1("bst", 1, 2'b00, 0, 32'h12, 32'h5A, 4, 32'h0, 0);
      chk("bst_waddr", lastWa1, 32'h10);
      chk("bst_datain", lastDin1, 32'hDE5ABEEF);
      txn1("hst", 1, 2'b01, 0, 32'h10, 32'h1234, 4, 32'h0, 0);
      chk("hst_datain", lastDin1, 32'hDE5A1234);
      chk("hst_mem", mem1[4], 32'hDE5A1234);

      // Extraction and extension
      txn1("wst2", 1, 2'b10, 0, 32'h20, 32'h80FF7F01, 2, 32'h0, 0);
      txn1("lb21s", 0, 2'b00, 0, 32'h21, 32'h0, 3, 32'h0000007F, 0);
      txn1("lb22s", 0, 2'b00, 0, 32'h22, 32'h0, 3, 32'hFFFFFFFF, 0);
      txn1("lh22s", 0, 2'b01, 0, 32'h22, 32'h0, 3, 32'hFFFF80FF, 0);
      txn1("lh22u", 0, 2'b01, 1, 32'h22, 32'h0, 3, 32'h000080FF, 0);
      txn1("lb23u", 0, 2'b00, 1, 32'h23, 32'h0, 3, 32'h00000080, 0);
      txn1("lb20s", 0, 2'b00, 0, 32'h20, 32'h0, 3, 32'h00000001, 0);

      // Misalignment and reserved size
      wc = wrCnt1;
      txn1("mis_wld", 0, 2'b10, 0, 32'h13, 32'h0, 1, 32'h0, 1);
      txn1("mis_hst", 1, 2'b01, 0, 32'h11, 32'hBEEF, 1, 32'h0, 1);
      txn1("mis_rsv", 0, 2'b11, 0, 32'h10, 32'h0, 1, 32'h0, 1);
      txn1("mis_wst", 1, 2'b10, 0, 32'h12, 32'h11111111, 1, 32'h0, 1);
      chk("mis_nowr", wrCnt1 - wc, 0);
      chk("mis_mem", mem1[4], 32'hDE5A1234);

      // Reset dropped while a byte store waits for its read
      rw1 = 1; rs1 = 2'b00; ru1 = 0; ra1 = 32'h10; rwd1 = 32'hAA; rv1 = 1;
      @(posedge Clk); #1;
      rv1 = 0;
      chk("rdw_busy", rdy1, 1'b0);
      wc = wrCnt1;
      vc = vldCnt1;
      Reset_n = 1'b0;
      #1;
      chk("rdw_wr", wr1, 1'b0);
      repeat (3) @(posedge Clk);
      #1;
      Reset_n = 1'b1;
      repeat (5) @(posedge Clk);
      #1;
      chk("rdw_nowr", wrCnt1 - wc, 0);
      chk("rdw_noresp", vldCnt1 - vc, 0);
      chk("rdw_ready", rdy1, 1'b1);
      chk("rdw_raddr", raddr1, 32'h0);
      chk("rdw_mem", mem1[4], 32'hDE5A1234);

      // Reset asserted during the WRITE cycle clears mem_wr at once
      old = mem1[12];
      rw1 = 1; rs1 = 2'b10; ru1 = 0; ra1 = 32'h30; rwd1 = 32'h55; rv1 = 1;
      @(posedge Clk); #1;
      rv1 = 0;
      chk("wrr_wr_hi", wr1, 1'b1);
      Reset_n = 1'b0;
      #1;
      chk("wrr_wr_lo", wr1, 1'b0);
      @(posedge Clk); #1;
      Reset_n = 1'b1;
      @(posedge Clk); #1;
      chk("wrr_mem", mem1[12], old);
      chk("wrr_ready", rdy1, 1'b1);

      // READ_LAT=3: four requests with req_valid held high
      rw3 = qW[0]; rs3 = qS[0]; ru3 = qU[0]; ra3 = qA[0]; rwd3 = qD[0]; rv3 = 1;
      for (int i = 0; i < 4; i++) begin
         waitC = 0;
         acc = 0;
         while (!acc && waitC < 50) begin
            acc = rdy3;
            @(posedge Clk); #1;
            waitC++;
         end
         chk($sformatf("hs%0d_gap", i), waitC, (i == 0) ? 1 : 2);
         lat = 1;
         busyBad = 0;
         while (!vld3 && lat < 20) begin
            if (rdy3) busyBad = 1;
            @(posedge Clk); #1;
            lat++;
         end
         if (rdy3) busyBad = 1;
         $display("txn u3 write=%0d size=%0d uns=%0d addr=%h wdata=%h lat=%0d rdata=%h err=%0d",
                  qW[i], qS[i], qU[i], qA[i], qD[i], lat, rdata3, err3);
         chk($sformatf("hs%0d_lat", i), lat, qLat[i]);
         chk($sformatf("hs%0d_busy", i), busyBad, 1'b0);
         chk($sformatf("hs%0d_rdata", i), rdata3, qRd[i]);
         chk($sformatf("hs%0d_err", i), err3, 1'b0);
         if (i < 3) begin
            rw3 = qW[i+1]; rs3 = qS[i+1]; ru3 = qU[i+1]; ra3 = qA[i+1]; rwd3 = qD[i+1];
         end else begin
            rv3 = 0;
         end
      end
      repeat (3) @(posedge Clk);
      #1;
      chk("hs_accepts", accCnt3, 4);
      chk("hs_mem", mem3[16], 32'hCAFE770D);
      chk("hs_ready", rdy3, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
